// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the core load/store path (c_*)
// and the test/program loader (l_*). A request is latched in IDLE, the memory
// strobe is driven for one cycle in ACCESS, reads wait out READ_LAT cycles in
// WAIT, and DONE returns a one-cycle ack to the winner. Ties between the two
// requesters alternate round-robin, starting with the core after reset.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds all of
// them until it sees ack (a single-cycle pulse). In the cycle after ack it may
// drop req or present a new request. Values changed while req is pending are
// ignored once latched; a req dropped before it is granted is simply lost.
//
// state_dbg exposes the FSM encoding: 0 IDLE, 1 ACCESS, 2 WAIT, 3 DONE.

module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,

    // core load/store port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,

    // loader port
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,

    // data memory side
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    // status / debug
    output logic          busy,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Requester identity, used both for the latched winner and last_grant.
    localparam logic ID_CORE = 1'b0;
    localparam logic ID_LDR  = 1'b1;

    // The WAIT counter runs 0 .. READ_LAT-1. With READ_LAT of 0 or 1 a single
    // bit is enough (and WAIT is never entered when READ_LAT is 0).
    localparam int CW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int LAT_M1 = (READ_LAT > 0) ? (READ_LAT - 1) : 0;

    state_t          state_q;
    state_t          state_d;

    logic            last_grant_q;
    logic            win_id_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   c_rdata_q;
    logic [DW-1:0]   l_rdata_q;
    logic [CW-1:0]   wait_cnt_q;

    logic            any_req;
    logic            pick_ldr;
    logic            wait_last;
    logic            capture_en;

    // Arbitration: a lone requester wins; on a tie the one that was not
    // granted last time wins. last_grant resets to the loader so the first
    // tie goes to the core.
    always_comb begin
        any_req  = c_req | l_req;
        pick_ldr = l_req & (~c_req | (last_grant_q == ID_CORE));
    end

    // End of the read-latency window and the cycle in which mem_rdata is taken.
    always_comb begin
        wait_last  = (wait_cnt_q == CW'(LAT_M1));
        capture_en = 1'b0;
        if (state_q == S_ACCESS && !we_q && READ_LAT == 0) begin
            capture_en = 1'b1;
        end else if (state_q == S_WAIT && wait_last) begin
            capture_en = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q || READ_LAT == 0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: memory strobes/address only in ACCESS/WAIT, ack only in DONE.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        c_ack     = 1'b0;
        l_ack     = 1'b0;
        unique case (state_q)
            S_ACCESS: begin
                mem_addr = addr_q;
                if (we_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_read  = 1'b1;
                end
            end
            S_WAIT: begin
                mem_addr = addr_q;
            end
            S_DONE: begin
                c_ack = (win_id_q == ID_CORE);
                l_ack = (win_id_q == ID_LDR);
            end
            default: begin
            end
        endcase
    end

    // Status outputs derived straight from the state register.
    always_comb begin
        busy      = (state_q != S_IDLE);
        state_dbg = state_q;
    end

    // Latch the winning request when leaving IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_id_q <= ID_CORE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == S_IDLE && any_req) begin
            if (pick_ldr) begin
                win_id_q <= ID_LDR;
                we_q     <= l_we;
                addr_q   <= l_addr;
                wdata_q  <= l_wdata;
            end else begin
                win_id_q <= ID_CORE;
                we_q     <= c_we;
                addr_q   <= c_addr;
                wdata_q  <= c_wdata;
            end
        end
    end

    // Read-latency counter: counts while in WAIT, cleared everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Capture read data into the winner's register only; the loser's is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else if (capture_en) begin
            if (win_id_q == ID_LDR) begin
                l_rdata_q <= mem_rdata;
            end else begin
                c_rdata_q <= mem_rdata;
            end
        end
    end

    // Remember who was served last; updated as the ack is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= ID_LDR;
        end else if (state_q == S_DONE) begin
            last_grant_q <= win_id_q;
        end
    end

    // Read data registers drive the ports directly.
    always_comb begin
        c_rdata = c_rdata_q;
        l_rdata = l_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter: a READ_LAT=1 instance with a registered
// memory model and a READ_LAT=0 instance with a combinational memory model.

module tb_dmem_arbiter;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (READ_LAT = 1) ----------------
    logic       c_req, c_we, c_ack;
    logic [7:0] c_addr, c_wdata, c_rdata;
    logic       l_req, l_we, l_ack;
    logic [7:0] l_addr, l_wdata, l_rdata;
    logic       mem_read, mem_write, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] state_dbg;

    dmem_arbiter #(.AW(8), .DW(8), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Memory model: one-cycle registered read, write on strobe, bench preload port.
    logic [7:0] mem [0:255];
    logic [7:0] rd_q;
    logic       bw_en;
    logic [7:0] bw_addr, bw_data;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (bw_en) mem[bw_addr] <= bw_data;
        if (mem_read) rd_q <= mem[mem_addr];
    end
    assign mem_rdata = rd_q;

    // ---------------- DUT (READ_LAT = 0) ----------------
    logic       z_c_req, z_c_we, z_c_ack;
    logic [7:0] z_c_addr, z_c_wdata, z_c_rdata;
    logic       z_l_ack;
    logic [7:0] z_l_rdata;
    logic       z_mem_read, z_mem_write, z_busy;
    logic [7:0] z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic [1:0] z_state_dbg;

    dmem_arbiter #(.AW(8), .DW(8), .READ_LAT(0)) dut_z (
        .clk(clk), .reset(reset),
        .c_req(z_c_req), .c_we(z_c_we), .c_addr(z_c_addr), .c_wdata(z_c_wdata),
        .c_ack(z_c_ack), .c_rdata(z_c_rdata),
        .l_req(1'b0), .l_we(1'b0), .l_addr(8'h00), .l_wdata(8'h00),
        .l_ack(z_l_ack), .l_rdata(z_l_rdata),
        .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
        .busy(z_busy), .state_dbg(z_state_dbg)
    );

    // Combinational memory: only 0x7F holds data.
    assign z_mem_rdata = (z_mem_addr == 8'h7F) ? 8'h81 : 8'h00;

    // ---------------- scoreboard ----------------
    int n_asrt = 0;
    int n_fail = 0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        c_req = 1'b0; l_req = 1'b0; z_c_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        bw_en = 1'b1; bw_addr = a; bw_data = d;
        tick();
        bw_en = 1'b0;
    endtask

    // Run until n grants are recorded in got_q (bounded), checking ack overlap.
    task automatic collect_grants(input string tag, input int n);
        for (int cyc = 0; cyc < 60 && got_q.size() < n; cyc++) begin
            tick();
            chk({tag, "_overlap"}, c_ack & l_ack, 0);
            if (c_ack) got_q.push_back(1'b0);
            if (l_ack) got_q.push_back(1'b1);
        end
        chk({tag, "_count"}, got_q.size(), n);
    endtask

    task automatic compare_order(input string tag);
        int i;
        i = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk($sformatf("%s_grant%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
            i++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    int ldr_idx;
    bit core_sent;

    initial begin
        c_we = 0; c_addr = 0; c_wdata = 0;
        l_we = 0; l_addr = 0; l_wdata = 0;
        z_c_we = 0; z_c_addr = 0; z_c_wdata = 0;
        bw_en = 0; bw_addr = 0; bw_data = 0;
        do_reset();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_acks", {c_ack, l_ack}, 0);
        chk("rst_rdata", {c_rdata, l_rdata}, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // 1: core write 0xA5 -> 0x10
        c_req = 1; c_we = 1; c_addr = 8'h10; c_wdata = 8'hA5;
        tick();
        chk("t1_c1_write", mem_write, 1);
        chk("t1_c1_read", mem_read, 0);
        chk("t1_c1_addr", mem_addr, 8'h10);
        chk("t1_c1_wdata", mem_wdata, 8'hA5);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_ack", c_ack, 0);
        tick();
        chk("t1_c2_ack", c_ack, 1);
        chk("t1_c2_lack", l_ack, 0);
        chk("t1_c2_busy", busy, 1);
        chk("t1_c2_write", mem_write, 0);
        chk("t1_c2_addr", mem_addr, 0);
        tick();
        c_req = 0;
        chk("t1_c3_ack", c_ack, 0);
        chk("t1_mem", mem[8'h10], 8'hA5);
        tick();
        chk("t1_idle", busy, 0);

        // 2: core read 0x10 with memory returning 0x3C
        preload(8'h10, 8'h3C);
        c_req = 1; c_we = 0; c_addr = 8'h10;
        tick();
        chk("t2_c1_read", mem_read, 1);
        chk("t2_c1_write", mem_write, 0);
        chk("t2_c1_addr", mem_addr, 8'h10);
        tick();
        chk("t2_c2_state", state_dbg, ST_WAIT);
        chk("t2_c2_read", mem_read, 0);
        chk("t2_c2_addr", mem_addr, 8'h10);
        chk("t2_c2_ack", c_ack, 0);
        tick();
        chk("t2_c3_ack", c_ack, 1);
        chk("t2_c3_rdata", c_rdata, 8'h3C);
        chk("t2_c3_lrdata", l_rdata, 0);
        tick();
        c_req = 0;
        chk("t2_c4_ack", c_ack, 0);
        chk("t2_c4_hold", c_rdata, 8'h3C);
        tick();

        // 3: tie from reset, both held -> core, loader, core, loader
        do_reset();
        c_we = 1; c_addr = 8'h40; c_wdata = 8'h11;
        l_we = 1; l_addr = 8'h41; l_wdata = 8'h22;
        c_req = 1; l_req = 1;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        collect_grants("t3", 4);
        c_req = 0; l_req = 0;
        compare_order("t3");
        tick();
        tick();
        chk("t3_mem40", mem[8'h40], 8'h11);
        chk("t3_mem41", mem[8'h41], 8'h22);

        // 4: loader streams 0x00..0x03; core read of 0x20 arrives mid-stream
        preload(8'h20, 8'h5A);
        l_we = 1; l_addr = 8'h00; l_wdata = 8'hC0; l_req = 1;
        ldr_idx = 0; core_sent = 0;
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int cyc = 0; cyc < 100 && got_q.size() < 5; cyc++) begin
            tick();
            chk("t4_overlap", c_ack & l_ack, 0);
            if (c_ack) begin
                got_q.push_back(1'b0);
                chk("t4_c_rdata", c_rdata, 8'h5A);
                chk("t4_l_rdata", l_rdata, 0);
                c_req = 0;
            end
            if (l_ack) begin
                got_q.push_back(1'b1);
                ldr_idx++;
                if (ldr_idx < 4) begin
                    l_addr = 8'(ldr_idx);
                    l_wdata = 8'hC0 | 8'(ldr_idx);
                end else begin
                    l_req = 0;
                end
            end
            if (!core_sent && ldr_idx == 1 && mem_write) begin
                c_req = 1; c_we = 0; c_addr = 8'h20;
                core_sent = 1;
            end
        end
        chk("t4_count", got_q.size(), 5);
        compare_order("t4");
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_mem%0d", i), mem[i], 8'hC0 | 8'(i));
        end

        // 5: reset pulsed low during WAIT of a core read
        c_req = 1; c_we = 0; c_addr = 8'h20;
        tick();
        chk("t5_c1_read", mem_read, 1);
        tick();
        chk("t5_c2_state", state_dbg, ST_WAIT);
        chk("t5_c2_busy", busy, 1);
        chk("t5_pre_rdata", c_rdata, 8'h5A);
        #2;
        reset = 0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_strobes", {mem_read, mem_write}, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_acks", {c_ack, l_ack}, 0);
        chk("t5_rst_rdata", {c_rdata, l_rdata}, 0);
        c_req = 0;
        tick();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_ack", {c_ack, l_ack, busy}, 0);
        end
        c_we = 1; c_addr = 8'h50; c_wdata = 8'h33;
        l_we = 1; l_addr = 8'h51; l_wdata = 8'h44;
        c_req = 1; l_req = 1;
        exp_q = '{1'b0};
        collect_grants("t5", 1);
        c_req = 0; l_req = 0;
        compare_order("t5");
        tick();
        tick();

        // 6: READ_LAT=0 instance, read 0x7F returning 0x81
        z_c_req = 1; z_c_we = 0; z_c_addr = 8'h7F;
        tick();
        chk("t6_c1_read", z_mem_read, 1);
        chk("t6_c1_addr", z_mem_addr, 8'h7F);
        chk("t6_c1_state", z_state_dbg, ST_ACCESS);
        tick();
        chk("t6_c2_state", z_state_dbg, ST_DONE);
        chk("t6_c2_ack", z_c_ack, 1);
        chk("t6_c2_rdata", z_c_rdata, 8'h81);
        chk("t6_c2_lack", z_l_ack, 0);
        chk("t6_c2_read", z_mem_read, 0);
        tick();
        z_c_req = 0;
        chk("t6_c3_ack", z_c_ack, 0);
        chk("t6_c3_lrdata", z_l_rdata, 0);
        tick();
        chk("t6_idle", {z_busy, z_mem_write}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
